// File: rtl/soc_led_fader_if.sv
// LED fader signal bundle: PIO target word and enable in, PWM drive and busy out.
interface soc_led_fader_if #(
  parameter int N_LEDS = 10
);
  logic [N_LEDS-1:0] led_req;
  logic              enable;
  logic [N_LEDS-1:0] led_out;
  logic              busy;

  modport master (output led_req, enable, input  led_out, busy);
  modport slave  (input  led_req, enable, output led_out, busy);
endinterface

// File: rtl/soc_led_fader.sv
// LED fader: per-channel linear brightness ramp with PWM drive between the PIO and LEDR pins.
// A shared prescaler paces the ramp; each lane owns its level, PWM compare and end-level test.
module soc_led_fader_lane #(
  parameter int PWM_BITS = 8,
  parameter int STEP     = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req,
  input  logic                enable,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led_out,
  output logic                mismatch
);
  localparam logic [PWM_BITS-1:0] MAX_V  = '1;
  localparam logic [PWM_BITS-1:0] STEP_V = PWM_BITS'(STEP);

  logic [PWM_BITS-1:0] level, level_up, level_dn, level_end;

  // Saturation tests compare against MAX-STEP / STEP so the add/sub never wraps
  assign level_up  = (level > (MAX_V - STEP_V)) ? MAX_V : level + STEP_V;
  assign level_dn  = (level < STEP_V) ? '0 : level - STEP_V;
  assign level_end = req ? MAX_V : '0;
  assign mismatch  = (level != level_end);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level   <= '0;
      led_out <= 1'b0;
    end else begin
      if (!enable)   level <= level_end;
      else if (tick) level <= req ? level_up : level_dn;
      led_out <= (level == MAX_V) | (level > pwm_cnt);
    end
  end
endmodule

module soc_led_fader #(
  parameter int N_LEDS   = 10,
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 50000,
  parameter int STEP     = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  soc_led_fader_if.slave io
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [N_LEDS-1:0]   led_req_q;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PW-1:0]       presc;
  logic                tick;
  logic [N_LEDS-1:0]   led_out_w, mismatch_w;

  assign tick = io.enable && (presc == PW'(PRESCALE - 1));

  // Prescaler is parked at 0 in bypass so re-entering fade mode starts a full period
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_req_q <= '0;
      pwm_cnt   <= '0;
      presc     <= '0;
    end else begin
      led_req_q <= io.led_req;
      pwm_cnt   <= pwm_cnt + 1'b1;
      if (!io.enable || tick) presc <= '0;
      else                    presc <= presc + 1'b1;
    end
  end

  for (genvar i = 0; i < N_LEDS; i++) begin : g_lane
    soc_led_fader_lane #(.PWM_BITS(PWM_BITS), .STEP(STEP)) u_lane (
      .clk      (clk),
      .reset_n  (reset_n),
      .req      (led_req_q[i]),
      .enable   (io.enable),
      .tick     (tick),
      .pwm_cnt  (pwm_cnt),
      .led_out  (led_out_w[i]),
      .mismatch (mismatch_w[i])
    );
  end

  assign io.led_out = led_out_w;
  assign io.busy    = |mismatch_w;
endmodule

// File: tb/tb_soc_led_fader.sv
// Directed bench for soc_led_fader: fast-fade instance (STEP=64, PRESCALE=4) and a slow
// STEP=128 instance used to hold a mid level long enough to measure PWM duty.
module tb_soc_led_fader;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  soc_led_fader_if #(.N_LEDS(10)) ifa ();
  soc_led_fader_if #(.N_LEDS(10)) ifb ();

  soc_led_fader #(.N_LEDS(10), .PWM_BITS(8), .PRESCALE(4), .STEP(64)) dut (
    .clk(clk), .reset_n(reset_n), .io(ifa.slave));
  soc_led_fader #(.N_LEDS(10), .PWM_BITS(8), .PRESCALE(1024), .STEP(128)) dut2 (
    .clk(clk), .reset_n(reset_n), .io(ifb.slave));

  always #5 clk = ~clk;

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset released at a negedge; the following posedge is edge E1.
  task automatic apply_reset(input logic [9:0] req, input logic en);
    @(negedge clk);
    reset_n = 1'b0; ifa.led_req = req; ifa.enable = en;
    ifb.led_req = '0; ifb.enable = 1'b0;
    wait_neg(2);
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; ifa.led_req = 10'h3FF; ifa.enable = 1'b1;
    ifb.led_req = '0; ifb.enable = 1'b0;
    wait_neg(3);
    checks++; if (ifa.led_out !== 10'h000) begin failures++; $display("FAIL reset_led_out: got %h expected 000", ifa.led_out); end
    checks++; if (ifa.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", ifa.busy); end
    reset_n = 1'b1;
    wait_neg(1);
    checks++; if (ifa.busy !== 1'b1) begin failures++; $display("FAIL reset_busy_e1: got %b expected 1", ifa.busy); end
    wait_neg(1);
    checks++; if (ifa.busy !== 1'b1) begin failures++; $display("FAIL reset_busy_e2: got %b expected 1", ifa.busy); end
    checks++; if (ifa.led_out !== 10'h000) begin failures++; $display("FAIL reset_led_out_e2: got %h expected 000", ifa.led_out); end
  endtask

  task automatic test_fade_up;
    int bad;
    apply_reset(10'h001, 1'b1);
    wait_neg(15);
    checks++; if (ifa.busy !== 1'b1) begin failures++; $display("FAIL fade_busy_e15: got %b expected 1", ifa.busy); end
    wait_neg(1);
    checks++; if (ifa.busy !== 1'b0) begin failures++; $display("FAIL fade_busy_e16: got %b expected 0", ifa.busy); end
    wait_neg(1);
    bad = 0;
    for (int k = 0; k < 24; k++) begin
      if (ifa.led_out !== 10'h001) bad++;
      wait_neg(1);
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL fade_full_on: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_reversal;
    apply_reset(10'h020, 1'b1);
    wait_neg(8);
    checks++; if (ifa.busy !== 1'b1) begin failures++; $display("FAIL rev_busy_128: got %b expected 1", ifa.busy); end
    ifa.led_req = 10'h000;
    wait_neg(4);
    checks++; if (ifa.busy !== 1'b1) begin failures++; $display("FAIL rev_busy_64: got %b expected 1", ifa.busy); end
    wait_neg(1);
    checks++; if (ifa.led_out !== 10'h020) begin failures++; $display("FAIL rev_led_out_64: got %h expected 020", ifa.led_out); end
    wait_neg(2);
    checks++; if (ifa.busy !== 1'b1) begin failures++; $display("FAIL rev_busy_e15: got %b expected 1", ifa.busy); end
    wait_neg(1);
    checks++; if (ifa.busy !== 1'b0) begin failures++; $display("FAIL rev_busy_e16: got %b expected 0", ifa.busy); end
    wait_neg(9);
    checks++; if (ifa.led_out !== 10'h000 || ifa.busy !== 1'b0) begin failures++; $display("FAIL rev_no_wrap: got led_out=%h busy=%b expected 000/0", ifa.led_out, ifa.busy); end
  endtask

  task automatic test_bypass;
    int bad;
    apply_reset(10'h000, 1'b0);
    wait_neg(2);
    ifa.led_req = 10'h2A5;
    wait_neg(1);
    checks++; if (ifa.led_out !== 10'h000) begin failures++; $display("FAIL byp_clk1: got %h expected 000", ifa.led_out); end
    wait_neg(1);
    checks++; if (ifa.led_out !== 10'h000) begin failures++; $display("FAIL byp_clk2: got %h expected 000", ifa.led_out); end
    checks++; if (ifa.busy !== 1'b0) begin failures++; $display("FAIL byp_busy: got %b expected 0", ifa.busy); end
    wait_neg(1);
    checks++; if (ifa.led_out !== 10'h2A5) begin failures++; $display("FAIL byp_clk3: got %h expected 2a5", ifa.led_out); end
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      wait_neg(1);
      if (ifa.led_out !== 10'h2A5) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL byp_static: got %0d bad cycles expected 0", bad); end
    // Opposite ramps on complementary channels finish on the same tick
    ifa.enable = 1'b1; ifa.led_req = 10'h15A;
    wait_neg(1);
    checks++; if (ifa.busy !== 1'b1 || ifa.led_out !== 10'h2A5) begin failures++; $display("FAIL byp_exit: got busy=%b led_out=%h expected 1/2a5", ifa.busy, ifa.led_out); end
    wait_neg(14);
    checks++; if (ifa.busy !== 1'b1) begin failures++; $display("FAIL byp_fade_e15: got %b expected 1", ifa.busy); end
    wait_neg(1);
    checks++; if (ifa.busy !== 1'b0) begin failures++; $display("FAIL byp_fade_e16: got %b expected 0", ifa.busy); end
    wait_neg(1);
    checks++; if (ifa.led_out !== 10'h15A) begin failures++; $display("FAIL byp_fade_end: got %h expected 15a", ifa.led_out); end
  endtask

  task automatic test_pwm_duty;
    int ones;
    apply_reset(10'h000, 1'b0);
    ifb.led_req = 10'h008; ifb.enable = 1'b1;
    wait_neg(1000);
    checks++; if (ifb.led_out !== 10'h000 || ifb.busy !== 1'b1) begin failures++; $display("FAIL duty_pre_tick: got led_out=%h busy=%b expected 000/1", ifb.led_out, ifb.busy); end
    wait_neg(100);
    ones = 0;
    for (int k = 0; k < 256; k++) begin
      if (ifb.led_out[3] === 1'b1) ones++;
      wait_neg(1);
    end
    checks++; if (ones != 128) begin failures++; $display("FAIL duty_128: got %0d high cycles expected 128", ones); end
    checks++; if (ifb.busy !== 1'b1) begin failures++; $display("FAIL duty_busy: got %b expected 1", ifb.busy); end
  endtask

  task automatic test_async_reset;
    apply_reset(10'h3FF, 1'b1);
    wait_neg(10);
    checks++; if (ifa.led_out !== 10'h3FF) begin failures++; $display("FAIL arst_pre: got %h expected 3ff", ifa.led_out); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (ifa.led_out !== 10'h000 || ifa.busy !== 1'b0) begin failures++; $display("FAIL arst_immediate: got led_out=%h busy=%b expected 000/0", ifa.led_out, ifa.busy); end
    @(negedge clk);
    reset_n = 1'b1;
    wait_neg(15);
    checks++; if (ifa.busy !== 1'b1) begin failures++; $display("FAIL arst_refade_e15: got %b expected 1", ifa.busy); end
    wait_neg(1);
    checks++; if (ifa.busy !== 1'b0) begin failures++; $display("FAIL arst_refade_e16: got %b expected 0", ifa.busy); end
  endtask

  initial begin
    ifa.led_req = '0; ifa.enable = 1'b0;
    ifb.led_req = '0; ifb.enable = 1'b0;
    test_reset();
    test_fade_up();
    test_reversal();
    test_bypass();
    test_pwm_duty();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
